univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parametrised successor to the datapath's 16-bit parallel-in/parallel-out load register. It adds synchronous clear, logical/arithmetic shift and rotate modes, serial in/out on both ends, and a multi-cycle "shift by N" sequencer with a busy/done handshake. It is intended as the generic operand register for the GCD and iterative-arithmetic datapaths, replacing hand-built load-plus-shift pairs.

## Interface
Parameters:
- `WIDTH`, 16, register width in bits (≥2).
- `AW`, $clog2(WIDTH+1), width of the shift-amount field.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  3  operation code, sampled with `start`.
- `amt`  in  AW  shift/rotate count, sampled with `start`; values > WIDTH are clamped to WIDTH.
- `data_in`  in  WIDTH  parallel load value.
- `ser_in_l`  in  1  bit shifted into the MSB on SHR.
- `ser_in_r`  in  1  bit shifted into the LSB on SHL.
- `data_out`  out  WIDTH  register contents.
- `ser_out_l`  out  1  = `data_out[WIDTH-1]`, combinational.
- `ser_out_r`  out  1  = `data_out[0]`, combinational.
- `busy`  out  1  high while a multi-cycle operation is in progress.
- `done`  out  1  one-cycle completion pulse, registered.

## Operation
- Op codes:
  - 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 CLR.
- Single-cycle ops (HOLD, LOAD, CLR): executed at the sampling edge.
  - LOAD: `data_out` ← `data_in`.
  - CLR: `data_out` ← 0.
  - HOLD: no change.
- Multi-cycle ops (2–6): one bit position per cycle, `amt` times.
  - SHL: shifts in `ser_in_r` at the LSB.
  - SHR: shifts in `ser_in_l` at the MSB.
  - ROL / ROR: wrap the bits around.
  - ASR: replicates the current MSB.
  - Serial inputs are sampled at each shift edge, not latched at start.
- FSM states:
  - IDLE: on `start`, a single-cycle op, or a multi-cycle op with `amt`=0, completes immediately (`done` next cycle, no data change for `amt`=0). A multi-cycle op with `amt`>0 latches op and count, then goes to SHIFT.
  - SHIFT: each edge performs one step and decrements the count. The step that takes the count from 1 to 0 returns to IDLE and raises `done`.
- `start` while `busy` is ignored; no queueing, and the in-flight op is unaffected.
- `data_in` changes during SHIFT have no effect.
- Reset (any time, including mid-SHIFT) forces:
  - `data_out`=0, `busy`=0, `done`=0, count=0, state IDLE.
  - The aborted operation never produces `done`.

## Timing
- Let edge k be the edge that samples `start`.
- Single-cycle op: `data_out` is valid after edge k, and `done` is high for the cycle between edges k and k+1.
- Shift by N (1 ≤ N ≤ WIDTH):
  - Steps occur at edges k+1 … k+N.
  - `busy` is high from after edge k through edge k+N.
  - `done` is high for exactly one cycle after edge k+N, with `busy` low in that cycle.
- A new `start` may be presented in the cycle `done` is high; it is accepted at the next edge.
- Throughput: one single-cycle op per cycle; N+1 cycles per N-bit shift.
- Reset values: `data_out`=0, `busy`=0, `done`=0. `ser_out_l` and `ser_out_r` follow `data_out`.

## Structure
- Shared package `shreg_pkg`:
  - 3-bit op enum with the codes above.
  - FSM state enum {IDLE, SHIFT}.
- One sub-module, `shreg_step`: a combinational one-position step (op, value, ser_in_l, ser_in_r → next value), reused by both single-bit and sequenced paths.
- The top level holds the register, the count register, the FSM and the `done` flop.

## Test plan
- Reset then LOAD 0xA5C3 (WIDTH=16): `data_out`=0xA5C3 after the edge, `done` for one cycle, `busy` never asserted.
- SHL `amt`=4 on 0xA5C3, `ser_in_r`=1 → 0x5C3F after 4 steps; `busy` high for 4 cycles, then `done` for one cycle.
- ASR `amt`=3 on 0x8010 → 0xF002; ROR `amt`=16 on 0x1234 → 0x1234; SHR `amt`=20 (clamped to 16) with `ser_in_l`=0 → 0x0000.
- `amt`=0 SHL on 0xBEEF → unchanged; `done` the next cycle; `busy` stays low.
- `start`=LOAD 0xFFFF mid-way through ROL `amt`=8 on 0x00FF → ignored; final value 0xFF00.
- Assert `rst` at step 2 of SHL `amt`=5 → `data_out`=0, `busy`=0 immediately, no `done`; a subsequent LOAD 0x0001 works normally.

Source files
------------

// File: rtl/shreg_pkg.sv
// shreg_pkg: shared op codes, FSM states and op classification for univ_shift_reg
package shreg_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_LOAD = 3'd1,
        OP_SHL  = 3'd2,
        OP_SHR  = 3'd3,
        OP_ROL  = 3'd4,
        OP_ROR  = 3'd5,
        OP_ASR  = 3'd6,
        OP_CLR  = 3'd7
    } op_e;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    // Shift/rotate ops run one bit per cycle under the sequencer; the rest finish in one edge.
    function automatic logic is_multi(op_e o);
        return !(o inside {OP_HOLD, OP_LOAD, OP_CLR});
    endfunction

endpackage

// File: rtl/shreg_step.sv
// shreg_step: combinational one-position step of the shift register
//   op_i     : operation code (shreg_pkg::op_e encoding)
//   val_i    : current register value
//   data_i   : parallel load value
//   ser_l_i  : bit entering the MSB on SHR
//   ser_r_i  : bit entering the LSB on SHL
//   nxt_o    : register value after one step of op_i
module shreg_step
    import shreg_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [2:0]       op_i,
    input  logic [WIDTH-1:0] val_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             ser_l_i,
    input  logic             ser_r_i,
    output logic [WIDTH-1:0] nxt_o
);

    always_comb begin
        case (op_e'(op_i))
            OP_HOLD: nxt_o = val_i;
            OP_LOAD: nxt_o = data_i;
            OP_SHL:  nxt_o = {val_i[WIDTH-2:0], ser_r_i};
            OP_SHR:  nxt_o = {ser_l_i, val_i[WIDTH-1:1]};
            OP_ROL:  nxt_o = {val_i[WIDTH-2:0], val_i[WIDTH-1]};
            OP_ROR:  nxt_o = {val_i[0], val_i[WIDTH-1:1]};
            OP_ASR:  nxt_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
            OP_CLR:  nxt_o = '0;
            default: nxt_o = val_i;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with load/clear and a shift-by-N sequencer
//   clk, rst           : clock, asynchronous active-high reset
//   start, op, amt     : request, op code and shift count (sampled in IDLE only)
//   data_in            : parallel load value
//   ser_in_l, ser_in_r : serial inputs at MSB (SHR) and LSB (SHL)
//   data_out           : register contents; ser_out_l/ser_out_r are its MSB/LSB
//   busy, done         : multi-cycle op in progress / one-cycle completion pulse
module univ_shift_reg
    import shreg_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int AW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] data_out,
    output logic             ser_out_l,
    output logic             ser_out_r,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             done_q, done_d;
    logic [AW-1:0]    amt_c;
    logic [2:0]       step_op;
    logic [WIDTH-1:0] step_val;

    assign amt_c   = (amt > AW'(WIDTH)) ? AW'(WIDTH) : amt;
    // While sequencing, the latched op drives the step so new requests cannot disturb it.
    assign step_op = (state_q == ST_SHIFT) ? op_q : op;

    shreg_step #(.WIDTH(WIDTH)) u_step (
        .op_i    (step_op),
        .val_i   (data_q),
        .data_i  (data_in),
        .ser_l_i (ser_in_l),
        .ser_r_i (ser_in_r),
        .nxt_o   (step_val)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                if (is_multi(op_e'(op)) && amt_c != '0) begin
                    op_d    = op_e'(op);
                    cnt_d   = amt_c;
                    state_d = ST_SHIFT;
                end else begin
                    done_d = 1'b1;
                    data_d = is_multi(op_e'(op)) ? data_q : step_val;
                end
            end
        end else begin
            data_d = step_val;
            cnt_d  = cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_HOLD;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign data_out  = data_q;
    assign ser_out_l = data_q[WIDTH-1];
    assign ser_out_r = data_q[0];
    assign busy      = (state_q == ST_SHIFT);
    assign done      = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: directed table-driven bench for univ_shift_reg (WIDTH=16)
module tb_univ_shift_reg;
    import shreg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [4:0]  amt = 5'd0;
    logic [15:0] data_in = 16'h0;
    logic        ser_in_l = 1'b0;
    logic        ser_in_r = 1'b0;
    logic [15:0] data_out;
    logic        ser_out_l, ser_out_r, busy, done;

    int total = 0;
    int bad = 0;

    univ_shift_reg #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .amt(amt),
        .data_in(data_in), .ser_in_l(ser_in_l), .ser_in_r(ser_in_r),
        .data_out(data_out), .ser_out_l(ser_out_l), .ser_out_r(ser_out_r),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  amt;
        logic [15:0] init;
        logic [15:0] din;
        logic        sil;
        logic        sir;
        logic [15:0] exp;
        int          nb;
    } vec_t;

    vec_t v[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] val);
        start = 1'b1; op = OP_LOAD; data_in = val; amt = 5'd0;
        tick();
        start = 1'b0;
        tick();
    endtask

    task automatic do_op(input string name, input logic [2:0] o, input logic [4:0] a,
                         input logic [15:0] din, input logic sil, input logic sir,
                         input logic [15:0] exp, input int nb);
        int n;
        start = 1'b1; op = o; amt = a; data_in = din; ser_in_l = sil; ser_in_r = sir;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            n++;
            tick();
        end
        chk({name, "_busy_cycles"}, n, nb);
        chk({name, "_done"}, {31'd0, done}, 32'd1);
        chk({name, "_data"}, {16'd0, data_out}, {16'd0, exp});
        tick();
        chk({name, "_done_off"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int n;
        int seen_done;
        v[0]  = '{OP_LOAD, 5'd0,  16'h0000, 16'hA5C3, 1'b0, 1'b0, 16'hA5C3, 0};
        v[1]  = '{OP_SHL,  5'd4,  16'hA5C3, 16'h0000, 1'b0, 1'b1, 16'h5C3F, 4};
        v[2]  = '{OP_ASR,  5'd3,  16'h8010, 16'h0000, 1'b0, 1'b0, 16'hF002, 3};
        v[3]  = '{OP_ROR,  5'd16, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h1234, 16};
        v[4]  = '{OP_SHR,  5'd20, 16'hABCD, 16'h0000, 1'b0, 1'b0, 16'h0000, 16};
        v[5]  = '{OP_SHL,  5'd0,  16'hBEEF, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 0};
        v[6]  = '{OP_CLR,  5'd0,  16'h1234, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 0};
        v[7]  = '{OP_HOLD, 5'd3,  16'h5A5A, 16'hFFFF, 1'b1, 1'b1, 16'h5A5A, 0};
        v[8]  = '{OP_ROL,  5'd1,  16'h8001, 16'h0000, 1'b0, 1'b0, 16'h0003, 1};
        v[9]  = '{OP_SHR,  5'd4,  16'h0F00, 16'h0000, 1'b1, 1'b0, 16'hF0F0, 4};
        v[10] = '{OP_ROR,  5'd4,  16'h1234, 16'h0000, 1'b0, 1'b0, 16'h4123, 4};
        v[11] = '{OP_ASR,  5'd4,  16'h7000, 16'h0000, 1'b0, 1'b0, 16'h0700, 4};
        v[12] = '{OP_SHL,  5'd16, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 16'h0000, 16};

        #2;
        chk("rst_data", {16'd0, data_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ser", {30'd0, ser_out_l, ser_out_r}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 13; i++) begin
            preload(v[i].init);
            do_op($sformatf("vec%0d", i), v[i].op, v[i].amt, v[i].din,
                  v[i].sil, v[i].sir, v[i].exp, v[i].nb);
        end

        // start while busy is ignored, as is data_in
        preload(16'h00FF);
        start = 1'b1; op = OP_ROL; amt = 5'd8; data_in = 16'h0000;
        tick();
        start = 1'b0;
        n = 0;
        while (busy && n < 40) begin
            if (n == 3) begin
                start = 1'b1; op = OP_LOAD; data_in = 16'hFFFF; amt = 5'd0;
            end
            if (n == 4) start = 1'b0;
            n++;
            tick();
        end
        start = 1'b0;
        chk("midstart_cycles", n, 8);
        chk("midstart_done", {31'd0, done}, 32'd1);
        chk("midstart_data", {16'd0, data_out}, 32'h0000FF00);
        chk("midstart_ser", {30'd0, ser_out_l, ser_out_r}, 32'd2);
        tick();

        // start in the done cycle is accepted at the next edge
        preload(16'h0001);
        start = 1'b1; op = OP_SHL; amt = 5'd1; ser_in_r = 1'b0;
        tick();
        start = 1'b0;
        tick();
        chk("b2b_done", {31'd0, done}, 32'd1);
        start = 1'b1; op = OP_LOAD; data_in = 16'h7777;
        tick();
        start = 1'b0;
        chk("b2b_data", {16'd0, data_out}, 32'h00007777);
        chk("b2b_done2", {31'd0, done}, 32'd1);
        tick();

        // reset mid-shift aborts without done
        preload(16'h1111);
        start = 1'b1; op = OP_SHL; amt = 5'd5; ser_in_r = 1'b0;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_data", {16'd0, data_out}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        #1 rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done || busy) seen_done = 1;
        end
        chk("abort_no_done", seen_done, 0);
        do_op("after_rst_load", OP_LOAD, 5'd0, 16'h0001, 1'b0, 1'b0, 16'h0001, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
